// File: rtl/sd_cmd_arb_pkg.sv
// sd_cmd_arb_pkg
// Shared types and constants for the SD command arbiter slice.
//   arb_state_t   : arbiter FSM states
//   OWNER_HOST/DM : encoding of cmd_owner and the round-robin memory
//   DEF_TMO_W/CYC : default timeout counter width and abort threshold
package sd_cmd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } arb_state_t;

  localparam logic OWNER_HOST = 1'b0;
  localparam logic OWNER_DM   = 1'b1;

  localparam int unsigned DEF_TMO_W   = 16;
  localparam logic [15:0] DEF_TMO_CYC = 16'hFFFF;

endpackage

// File: rtl/sd_cmd_arb_timer.sv
// sd_cmd_arb_timer
// Saturating cycle counter that bounds how long the arbiter waits on the
// command master.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (takes priority over en)
//   en         : count one cycle
//   last       : the increment taken this cycle brings the count to TMO_CYC
module sd_cmd_arb_timer #(
  parameter int unsigned      TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_CYC = {TMO_W{1'b1}}
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic last
);

  // Flagging one count early lets the FSM abort on the same edge the count
  // reaches TMO_CYC, so the abort lands exactly TMO_CYC cycles after entry.
  localparam logic [TMO_W-1:0] LAST_VAL = TMO_CYC - TMO_W'(1);

  logic [TMO_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != {TMO_W{1'b1}})) begin
      count_q <= count_q + TMO_W'(1);
    end
  end

  assign last = (count_q >= LAST_VAL);

endmodule

// File: rtl/sd_cmd_arbiter.sv
// sd_cmd_arbiter
// Round-robin arbiter that shares the SD command master between host
// register writes and the data master's command-setting handshake.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   host_req/arg/set, host_ack : host command request and one-cycle ack
//   dm_req/arg/set, dm_ack     : data master request (we_req) and ack (we_ack)
//   cmd_busy                   : command master busy
//   cmd_arg, cmd_set           : latched command to the command master
//   cmd_start                  : one-cycle start strobe
//   cmd_owner                  : 0 = host, 1 = data master
//   arb_busy                   : arbiter not idle
//   tmo_err, err_clr           : sticky timeout flag and its clear
module sd_cmd_arbiter
  import sd_cmd_arb_pkg::*;
#(
  parameter int unsigned      ARG_W   = 32,
  parameter int unsigned      SET_W   = 16,
  parameter int unsigned      TMO_W   = DEF_TMO_W,
  parameter logic [TMO_W-1:0] TMO_CYC = TMO_W'(DEF_TMO_CYC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             host_req,
  input  logic [ARG_W-1:0] host_arg,
  input  logic [SET_W-1:0] host_set,
  output logic             host_ack,
  input  logic             dm_req,
  input  logic [ARG_W-1:0] dm_arg,
  input  logic [SET_W-1:0] dm_set,
  output logic             dm_ack,
  input  logic             cmd_busy,
  output logic [ARG_W-1:0] cmd_arg,
  output logic [SET_W-1:0] cmd_set,
  output logic             cmd_start,
  output logic             cmd_owner,
  output logic             arb_busy,
  output logic             tmo_err,
  input  logic             err_clr
);

  arb_state_t       state_q, state_d;
  logic             last_owner_q, last_owner_d;
  logic             host_ack_q, host_ack_d;
  logic             dm_ack_q, dm_ack_d;
  logic             cmd_start_q, cmd_start_d;
  logic             cmd_owner_q, cmd_owner_d;
  logic             arb_busy_q, arb_busy_d;
  logic             tmo_err_q, tmo_err_d;
  logic [ARG_W-1:0] cmd_arg_q, cmd_arg_d;
  logic [SET_W-1:0] cmd_set_q, cmd_set_d;

  logic winner;
  logic tmr_clr, tmr_en, tmr_last, tmo_hit;

  sd_cmd_arb_timer #(
    .TMO_W  (TMO_W),
    .TMO_CYC(TMO_CYC)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .last (tmr_last)
  );

  // A lone requester wins outright; on a tie the side that did not win
  // last time goes first. last_owner resets to host, so dm wins the first tie.
  always_comb begin
    if (host_req && dm_req) begin
      winner = ~last_owner_q;
    end else if (dm_req) begin
      winner = OWNER_DM;
    end else begin
      winner = OWNER_HOST;
    end
  end

  // Next-state and next-output logic. Every output is registered, so the
  // values computed here appear one edge later.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    host_ack_d   = 1'b0;
    dm_ack_d     = 1'b0;
    cmd_start_d  = 1'b0;
    cmd_owner_d  = cmd_owner_q;
    cmd_arg_d    = cmd_arg_q;
    cmd_set_d    = cmd_set_q;
    tmr_clr      = 1'b0;
    tmr_en       = 1'b0;
    tmo_hit      = 1'b0;

    case (state_q)
      IDLE: begin
        // cmd_busy is deliberately not looked at here.
        if (host_req || dm_req) begin
          cmd_owner_d  = winner;
          last_owner_d = winner;
          if (winner == OWNER_DM) begin
            cmd_arg_d = dm_arg;
            cmd_set_d = dm_set;
            dm_ack_d  = 1'b1;
          end else begin
            cmd_arg_d  = host_arg;
            cmd_set_d  = host_set;
            host_ack_d = 1'b1;
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        cmd_start_d = 1'b1;
        tmr_clr     = 1'b1;
        state_d     = WAIT_START;
      end

      WAIT_START: begin
        tmr_en = 1'b1;
        if (tmr_last) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end else if (cmd_busy) begin
          state_d = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        tmr_en = 1'b1;
        if (tmr_last) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end else if (!cmd_busy) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    arb_busy_d = (state_d != IDLE);
    // A timeout on the same edge as err_clr must leave the flag set.
    tmo_err_d  = tmo_hit | (tmo_err_q & ~err_clr);
  end

  // State and output registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_HOST;
      host_ack_q   <= 1'b0;
      dm_ack_q     <= 1'b0;
      cmd_start_q  <= 1'b0;
      cmd_owner_q  <= OWNER_HOST;
      arb_busy_q   <= 1'b0;
      tmo_err_q    <= 1'b0;
      cmd_arg_q    <= '0;
      cmd_set_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      host_ack_q   <= host_ack_d;
      dm_ack_q     <= dm_ack_d;
      cmd_start_q  <= cmd_start_d;
      cmd_owner_q  <= cmd_owner_d;
      arb_busy_q   <= arb_busy_d;
      tmo_err_q    <= tmo_err_d;
      cmd_arg_q    <= cmd_arg_d;
      cmd_set_q    <= cmd_set_d;
    end
  end

  assign host_ack  = host_ack_q;
  assign dm_ack    = dm_ack_q;
  assign cmd_start = cmd_start_q;
  assign cmd_owner = cmd_owner_q;
  assign arb_busy  = arb_busy_q;
  assign tmo_err   = tmo_err_q;
  assign cmd_arg   = cmd_arg_q;
  assign cmd_set   = cmd_set_q;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// tb_sd_cmd_arbiter
// Scoreboard bench for sd_cmd_arbiter. The stimulus side predicts the grant
// order from the round-robin rule and queues the expected commands; a monitor
// pops them whenever an ack appears and checks the latched command, the start
// strobe, grant spacing and timeout behaviour. A responder plays the command
// master's busy handshake.
module tb_sd_cmd_arbiter;
  import sd_cmd_arb_pkg::*;

  localparam int TMO = 8;

  typedef struct packed {
    logic [31:0] arg;
    logic [15:0] set;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_req, dm_req, cmd_busy, err_clr;
  logic [31:0] host_arg, dm_arg;
  logic [15:0] host_set, dm_set;
  logic        host_ack, dm_ack, cmd_start, cmd_owner, arb_busy, tmo_err;
  logic [31:0] cmd_arg;
  logic [15:0] cmd_set;

  // Scoreboard state
  req_t hostQ[$];
  req_t dmQ[$];
  logic ownerQ[$];
  int   asserts = 0;
  int   fails = 0;
  int   expStarts = 0;
  int   startCount = 0;
  int   cyc = 0;
  int   lastAckCyc = -1;
  int   spacing = 0;
  int   resetEpoch = 0;

  // Reference model / stimulus state
  logic lastOwner = OWNER_HOST;
  logic pendH = 1'b0, pendD = 1'b0;
  int   leftH = 0, leftD = 0;

  // Responder configuration
  logic noBusy = 1'b0;
  int   busyDelay = 0;
  int   busyLen = 1;

  sd_cmd_arbiter #(
    .ARG_W  (32),
    .SET_W  (16),
    .TMO_W  (16),
    .TMO_CYC(16'(TMO))
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .host_req (host_req),
    .host_arg (host_arg),
    .host_set (host_set),
    .host_ack (host_ack),
    .dm_req   (dm_req),
    .dm_arg   (dm_arg),
    .dm_set   (dm_set),
    .dm_ack   (dm_ack),
    .cmd_busy (cmd_busy),
    .cmd_arg  (cmd_arg),
    .cmd_set  (cmd_set),
    .cmd_start(cmd_start),
    .cmd_owner(cmd_owner),
    .arb_busy (arb_busy),
    .tmo_err  (tmo_err),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    asserts++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Present a fresh randomized request on one side and queue its payload.
  task automatic applyStimulus(input logic side);
    req_t r;
    r.arg = $urandom;
    r.set = 16'($urandom);
    if (side == OWNER_DM) begin
      dm_arg = r.arg; dm_set = r.set; dm_req = 1'b1; pendD = 1'b1;
      dmQ.push_back(r);
    end else begin
      host_arg = r.arg; host_set = r.set; host_req = 1'b1; pendH = 1'b1;
      hostQ.push_back(r);
    end
  endtask

  task automatic waitAck(output bit got);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (host_ack || dm_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkOutput("ack_timeout", {63'd0, host_ack | dm_ack}, 64'd1);
  endtask

  task automatic waitIdle();
    bit idle = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (!arb_busy) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) checkOutput("idle_timeout", {63'd0, arb_busy}, 64'd0);
  endtask

  // Serve every pending request: predict each winner with the round-robin
  // rule, then after its ack either re-request with new data or drop.
  task automatic serveLoop();
    logic winner;
    bit   got;
    while (pendH || pendD) begin
      winner = (pendH && pendD) ? ~lastOwner : pendD;
      ownerQ.push_back(winner);
      lastOwner = winner;
      expStarts++;
      waitAck(got);
      if (!got) begin
        host_req = 1'b0; dm_req = 1'b0; pendH = 1'b0; pendD = 1'b0;
      end else begin
        @(negedge clk);
        if (winner == OWNER_DM) begin
          if (leftD > 0) begin applyStimulus(OWNER_DM); leftD--; end
          else begin dm_req = 1'b0; pendD = 1'b0; end
        end else begin
          if (leftH > 0) begin applyStimulus(OWNER_HOST); leftH--; end
          else begin host_req = 1'b0; pendH = 1'b0; end
        end
      end
    end
  endtask

  // Single dm command with the default payload path; returns after the ack.
  task automatic singleDm(output bit got);
    @(negedge clk);
    applyStimulus(OWNER_DM);
    ownerQ.push_back(OWNER_DM);
    lastOwner = OWNER_DM;
    expStarts++;
    waitAck(got);
    @(negedge clk);
    dm_req = 1'b0;
    pendD = 1'b0;
  endtask

  // Command master model: answers each start strobe with a busy pulse.
  initial begin : responder
    int myEpoch;
    cmd_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && cmd_start && !noBusy) begin
        myEpoch = resetEpoch;
        @(negedge clk);
        repeat (busyDelay) @(negedge clk);
        cmd_busy = 1'b1;
        for (int i = 0; i < busyLen; i++) begin
          @(negedge clk);
          if (resetEpoch != myEpoch) break;
        end
        cmd_busy = 1'b0;
        if (resetEpoch == myEpoch) begin
          @(posedge clk); #1;
          checkOutput("arb_busy_release", {63'd0, arb_busy}, 64'd0);
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an ack.
  initial begin : monitor
    logic expStart, startNext, expOwner, tmoActive;
    int   tmoN;
    req_t expReq;
    logic [31:0] lastArg;
    logic [15:0] lastSet;
    startNext = 1'b0; tmoActive = 1'b0; tmoN = 0; lastArg = '0; lastSet = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        startNext = 1'b0; tmoActive = 1'b0; lastArg = '0; lastSet = '0;
      end else begin
        expStart  = startNext;
        startNext = host_ack | dm_ack;
        checkOutput("cmd_start_timing", {63'd0, cmd_start}, {63'd0, expStart});
        startCount += int'(cmd_start);
        checkOutput("ack_exclusive", {63'd0, host_ack & dm_ack}, 64'd0);
        if (host_ack || dm_ack) begin
          if (ownerQ.size() == 0) begin
            checkOutput("unexpected_ack", {62'd0, host_ack, dm_ack}, 64'd0);
          end else begin
            expOwner = ownerQ.pop_front();
            checkOutput("grant_owner", {63'd0, dm_ack}, {63'd0, expOwner});
            checkOutput("cmd_owner", {63'd0, cmd_owner}, {63'd0, expOwner});
            if (expOwner == OWNER_DM && dmQ.size() > 0) expReq = dmQ.pop_front();
            else if (expOwner == OWNER_HOST && hostQ.size() > 0) expReq = hostQ.pop_front();
            else expReq = '0;
            checkOutput("cmd_arg", {32'd0, cmd_arg}, {32'd0, expReq.arg});
            checkOutput("cmd_set", {48'd0, cmd_set}, {48'd0, expReq.set});
            lastArg = expReq.arg;
            lastSet = expReq.set;
            if (spacing > 0 && lastAckCyc >= 0)
              checkOutput("grant_spacing", 64'(cyc - lastAckCyc), 64'(spacing));
            lastAckCyc = cyc;
          end
        end else begin
          checkOutput("cmd_arg_hold", {32'd0, cmd_arg}, {32'd0, lastArg});
          checkOutput("cmd_set_hold", {48'd0, cmd_set}, {48'd0, lastSet});
        end
        if (cmd_start && noBusy) begin
          tmoActive = 1'b1;
          tmoN = 0;
        end else if (tmoActive) begin
          tmoN++;
          if (tmoN == TMO - 1) checkOutput("tmo_not_early", {63'd0, arb_busy}, 64'd1);
          if (tmoN == TMO) begin
            checkOutput("tmo_err_set", {63'd0, tmo_err}, 64'd1);
            checkOutput("tmo_to_idle", {63'd0, arb_busy}, 64'd0);
            tmoActive = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    bit got;
    logic mode_dm, mode_h;
    int mode;
    rst_n = 1'b1;
    host_req = 1'b0; dm_req = 1'b0; err_clr = 1'b0;
    host_arg = '0; host_set = '0; dm_arg = '0; dm_set = '0;
    #2 rst_n = 1'b0;

    // Reset values, with both requests already pending
    applyStimulus(OWNER_DM);
    applyStimulus(OWNER_HOST);
    #1;
    checkOutput("reset_ctrl", {58'd0, host_ack, dm_ack, cmd_start, arb_busy, cmd_owner, tmo_err}, 64'd0);
    checkOutput("reset_arg", {32'd0, cmd_arg}, 64'd0);
    checkOutput("reset_set", {48'd0, cmd_set}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] both requesters held for six commands");
    lastOwner = OWNER_HOST; leftD = 2; leftH = 2;
    busyDelay = 0; busyLen = 1; spacing = 4; lastAckCyc = -1;
    serveLoop();
    waitIdle();

    // Directed dm-only command with fixed payload
    $display("[TB] single dm command");
    spacing = 0; busyLen = 3;
    @(negedge clk);
    dm_arg = 32'h0000_0200; dm_set = 16'h0C1A; dm_req = 1'b1;
    dmQ.push_back('{arg: 32'h0000_0200, set: 16'h0C1A});
    ownerQ.push_back(OWNER_DM); lastOwner = OWNER_DM; expStarts++;
    @(posedge clk); #1;
    checkOutput("first_ack_latency", {63'd0, dm_ack}, 64'd1);
    @(negedge clk);
    dm_req = 1'b0;
    waitIdle();

    // Host pulse while dm owns the command master is never granted
    $display("[TB] host pulse during dm ownership");
    busyLen = 5;
    singleDm(got);
    @(negedge clk);
    host_req = 1'b1; host_arg = $urandom;
    @(negedge clk);
    host_req = 1'b0;
    waitIdle();
    checkOutput("no_extra_start", 64'(startCount), 64'(expStarts));

    // Timeout, clear, and clear coincident with a second timeout
    $display("[TB] timeout handling");
    noBusy = 1'b1;
    singleDm(got);
    waitIdle();
    checkOutput("tmo_sticky", {63'd0, tmo_err}, 64'd1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    @(posedge clk); #1;
    checkOutput("tmo_clear", {63'd0, tmo_err}, 64'd0);
    @(negedge clk);
    applyStimulus(OWNER_DM);
    ownerQ.push_back(OWNER_DM); lastOwner = OWNER_DM; expStarts++;
    waitAck(got);
    @(negedge clk); dm_req = 1'b0; pendD = 1'b0;
    repeat (TMO) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    @(posedge clk); #1;
    checkOutput("tmo_set_wins", {63'd0, tmo_err}, 64'd1);
    waitIdle();
    noBusy = 1'b0;

    // Randomized segments
    $display("[TB] randomized segments");
    for (int s = 0; s < 12; s++) begin
      mode = $urandom_range(0, 2);
      mode_dm = (mode != 0);
      mode_h  = (mode != 1);
      noBusy = ($urandom_range(0, 4) == 0);
      busyDelay = $urandom_range(0, 2);
      busyLen = $urandom_range(1, 4);
      spacing = noBusy ? TMO + 2 : 3 + busyDelay + busyLen;
      lastAckCyc = -1;
      leftD = 0; leftH = 0;
      @(negedge clk);
      if (mode_dm) begin applyStimulus(OWNER_DM); leftD = $urandom_range(0, 3); end
      if (mode_h) begin applyStimulus(OWNER_HOST); leftH = $urandom_range(0, 3); end
      serveLoop();
      waitIdle();
    end
    noBusy = 1'b0;

    // Reset during WAIT_DONE aborts and restores the round-robin pointer
    $display("[TB] reset during an active command");
    spacing = 0; busyDelay = 0; busyLen = 6;
    @(negedge clk);
    applyStimulus(OWNER_DM);
    ownerQ.push_back(OWNER_DM); lastOwner = OWNER_DM; expStarts++;
    waitAck(got);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    resetEpoch++;
    #1;
    checkOutput("midreset_ctrl", {58'd0, host_ack, dm_ack, cmd_start, arb_busy, cmd_owner, tmo_err}, 64'd0);
    checkOutput("midreset_arg", {32'd0, cmd_arg}, 64'd0);
    checkOutput("midreset_set", {48'd0, cmd_set}, 64'd0);
    ownerQ.delete(); hostQ.delete(); dmQ.delete();
    lastOwner = OWNER_HOST;
    leftD = 0; leftH = 0;
    applyStimulus(OWNER_DM);
    applyStimulus(OWNER_HOST);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    serveLoop();
    waitIdle();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("pending_grants", 64'(ownerQ.size()), 64'd0);
    checkOutput("start_count", 64'(startCount), 64'(expStarts));
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
